// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory port between the CPU (requester 0) and a debug master
// (requester 1). Defining DMEM_ARB_LOCK_EN builds the bounded debug bus lock.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    input  logic          dbg_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    lock_state_e    lock_q, lock_d;
    logic [LCW-1:0] lock_cnt, lock_cnt_d;
    logic           rr, rr_d;
    logic           owner_q, owner_d;
    logic           rd_pend_q, rd_pend_d;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q, cpu_rdata_q, dbg_rdata_q;
    logic           both_req, forced_rel;

    assign both_req = cpu_req && dbg_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q      <= StUnlocked;
            lock_cnt    <= '0;
            rr          <= 1'b0;
            owner_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_cnt    <= lock_cnt_d;
            rr          <= rr_d;
            owner_q     <= owner_d;
            rd_pend_q   <= rd_pend_d;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            cpu_rdata_q <= cpu_rdata;
            dbg_rdata_q <= dbg_rdata;
        end
    end

    always_comb begin
        rd_pend_d = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
        owner_d   = owner_q;
        if (cpu_gnt && !cpu_we) begin
            owner_d = 1'b0;
        end else if (dbg_gnt && !dbg_we) begin
            owner_d = 1'b1;
        end
        // After a contended grant the loser becomes the favourite.
        rr_d = rr;
        if (both_req && (cpu_gnt || dbg_gnt)) begin
            rr_d = cpu_gnt;
        end
`ifdef DMEM_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt;
        forced_rel = 1'b0;
        unique case (lock_q)
            StUnlocked: begin
                if (dbg_gnt && dbg_lock) begin
                    if (LOCK_MAX <= 1) begin
                        forced_rel = 1'b1;
                    end else begin
                        lock_d     = StLocked;
                        lock_cnt_d = LCW'(1);
                    end
                end
            end
            StLocked: begin
                lock_cnt_d = lock_cnt + LCW'(dbg_gnt);
                forced_rel = (lock_cnt + LCW'(dbg_gnt)) == LCW'(LOCK_MAX);
                if (forced_rel || !dbg_lock) begin
                    lock_d     = StUnlocked;
                    lock_cnt_d = '0;
                end
            end
            default: lock_d = StUnlocked;
        endcase
`else
        lock_d     = StUnlocked;
        lock_cnt_d = '0;
        forced_rel = 1'b0;
`endif
        if (forced_rel) begin
            rr_d = 1'b0;
        end
    end

`ifndef DMEM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = dbg_lock ^ (|lock_cnt);
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            if (lock_q == StLocked) begin
                dbg_gnt = dbg_req;
            end else if (both_req) begin
                dbg_gnt = rr;
                cpu_gnt = !rr;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end

        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end

        cpu_rvalid = !reset && rd_pend_q && !owner_q;
        dbg_rvalid = !reset && rd_pend_q && owner_q;
        cpu_rdata  = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
        dbg_rdata  = reset ? '0 : (dbg_rvalid ? mem_rdata : dbg_rdata_q);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a behavioural model,
// with a small synchronous memory attached to the mem_* port.
module tb_dmem_arbiter;

    localparam int unsigned LOCK_MAX = 4;

    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        sram_init;
    logic [31:0] sram    [16];
    logic [31:0] ref_mem [16];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
        end else begin
            if (mem_we) sram[mem_addr[5:2]] <= mem_wdata;
            mem_rdata <= sram[mem_addr[5:2]];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_req  = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        reset    = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h2222_2222;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we} !== 5'b0) begin
                bad++;
                $display("FAIL reset_ctrl cyc=%0d got=%b exp=00000", c,
                         {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we});
            end
            total++;
            if ({cpu_rdata, dbg_rdata, mem_addr, mem_wdata} !== 128'd0) begin
                bad++;
                $display("FAIL reset_data cyc=%0d got=%h exp=0", c,
                         {cpu_rdata, dbg_rdata, mem_addr, mem_wdata});
            end
            next_cycle();
        end
        reset = 1'b0;
        dbg_we = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL reset_first_gnt got=%b exp=10", {cpu_gnt, dbg_gnt});
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic prev_dbg;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        prev_dbg = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            @(negedge clk);
            if (c < 6) begin
                total++;
                if ({cpu_gnt, dbg_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL contention_gnt cyc=%0d got=%b exp=%b", c, {cpu_gnt, dbg_gnt},
                             (c % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (c > 0) begin
                total++;
                if ({cpu_rvalid, dbg_rvalid} !== {!prev_dbg, prev_dbg}) begin
                    bad++;
                    $display("FAIL contention_rvalid cyc=%0d got=%b exp=%b", c,
                             {cpu_rvalid, dbg_rvalid}, {!prev_dbg, prev_dbg});
                end
                total++;
                if ((prev_dbg ? dbg_rdata : cpu_rdata) !== ref_mem[prev_dbg ? 8 : 4]) begin
                    bad++;
                    $display("FAIL contention_rdata cyc=%0d got=%h exp=%h", c,
                             prev_dbg ? dbg_rdata : cpu_rdata, ref_mem[prev_dbg ? 8 : 4]);
                end
            end
            prev_dbg = (c % 2 == 1);
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({dbg_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h8, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL wr_port got=%b/%b/%h/%h exp=1/1/8/deadbeef", dbg_gnt, mem_we,
                     mem_addr, mem_wdata);
        end
        ref_mem[2] = 32'hDEAD_BEEF;
        next_cycle();
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        @(negedge clk);
        total++;
        if ({cpu_gnt, cpu_rvalid, dbg_rvalid} !== 3'b100) begin
            bad++;
            $display("FAIL wr_rd_grant got=%b exp=100", {cpu_gnt, cpu_rvalid, dbg_rvalid});
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL wr_rd_return got=%b/%b/%h exp=1/0/deadbeef", cpu_rvalid, dbg_rvalid,
                     cpu_rdata);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({cpu_rvalid, dbg_rvalid, mem_we, mem_addr} !== {3'b000, 32'h8}) begin
            bad++;
            $display("FAIL wr_rd_idle got=%b/%b/%b/%h exp=0/0/0/8", cpu_rvalid, dbg_rvalid,
                     mem_we, mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_lock_release();
        logic [6:0] exp_dbg;
`ifdef DMEM_ARB_LOCK_EN
        exp_dbg = 7'b1011110;
`else
        exp_dbg = 7'b0101010;
`endif
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_lock = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            total++;
            if ({cpu_gnt, dbg_gnt} !== {!exp_dbg[c], exp_dbg[c]}) begin
                bad++;
                $display("FAIL lock_seq cyc=%0d got=%b exp=%b", c, {cpu_gnt, dbg_gnt},
                         {!exp_dbg[c], exp_dbg[c]});
            end
            next_cycle();
        end
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_rd_grant got=%b exp=1", cpu_gnt);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== 34'd0) begin
            bad++;
            $display("FAIL mid_rd_drop got=%b/%b/%h exp=0/0/0", cpu_rvalid, dbg_rvalid, cpu_rdata);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid} !== 3'b100) begin
            bad++;
            $display("FAIL mid_rd_rr_reset got=%b exp=100", {cpu_gnt, dbg_gnt, cpu_rvalid});
        end
        next_cycle();
        // Leave rr pointing at debug and take the lock, then reset again.
        cpu_req = 1'b0; dbg_lock = 1'b1;
        @(negedge clk);
        total++;
        if ({dbg_gnt, cpu_rvalid, cpu_rdata} !== {2'b11, ref_mem[1]}) begin
            bad++;
            $display("FAIL mid_rd_lock_take got=%b/%b/%h exp=1/1/%h", dbg_gnt, cpu_rvalid,
                     cpu_rdata, ref_mem[1]);
        end
        next_cycle();
        reset = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        total++;
        if ({dbg_rvalid, dbg_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL mid_rd_dbg_drop got=%b exp=00", {dbg_rvalid, dbg_gnt});
        end
        next_cycle();
        reset = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_gnt, dbg_gnt, dbg_rvalid} !== 3'b100) begin
            bad++;
            $display("FAIL mid_rd_state_reset got=%b exp=100", {cpu_gnt, dbg_gnt, dbg_rvalid});
        end
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cpu_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cpu_req  = (c < 3);
            cpu_addr = 32'(c * 4);
            @(negedge clk);
            total++;
            if ({cpu_gnt, cpu_rvalid} !== {c < 3, c >= 1 && c <= 3}) begin
                bad++;
                $display("FAIL b2b_ctrl cyc=%0d got=%b exp=%b", c, {cpu_gnt, cpu_rvalid},
                         {c < 3, c >= 1 && c <= 3});
            end
            if (c >= 1) begin
                total++;
                if (cpu_rdata !== ref_mem[(c > 3) ? 2 : c - 1]) begin
                    bad++;
                    $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, cpu_rdata,
                             ref_mem[(c > 3) ? 2 : c - 1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic        cpu_pend, dbg_pend, w_cpu, w_dbg, e_we;
        logic        r_valid, r_owner, n_valid, n_owner;
        logic [31:0] e_addr, e_wdata, e_crd, e_drd, r_data, n_data;
        logic        favour, locked;
        int          lock_grants;
        do_reset();
        favour = 1'b0; locked = 1'b0; lock_grants = 0;
        e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
        r_valid = 1'b0; r_owner = 1'b0; r_data = '0;
        cpu_pend = 1'b0; dbg_pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!cpu_pend) begin
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                cpu_wdata = $urandom;
            end
            if (!dbg_pend) begin
                dbg_req   = 1'($urandom_range(0, 1));
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                dbg_wdata = $urandom;
            end
            dbg_lock = ($urandom_range(0, 3) != 0);

            // Who should win this cycle.
            if (locked) begin
                w_cpu = 1'b0;
                w_dbg = dbg_req;
            end else if (cpu_req && dbg_req) begin
                w_cpu = !favour;
                w_dbg = favour;
            end else begin
                w_cpu = cpu_req;
                w_dbg = dbg_req;
            end
            if (w_cpu) begin
                e_addr = cpu_addr; e_wdata = cpu_wdata;
            end else if (w_dbg) begin
                e_addr = dbg_addr; e_wdata = dbg_wdata;
            end
            e_we = (w_cpu && cpu_we) || (w_dbg && dbg_we);
            if (r_valid && !r_owner) e_crd = r_data;
            if (r_valid && r_owner) e_drd = r_data;

            @(negedge clk);
            total++;
            if ({cpu_gnt, dbg_gnt} !== {w_cpu, w_dbg}) begin
                bad++;
                $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {cpu_gnt, dbg_gnt}, {w_cpu, w_dbg});
            end
            total++;
            if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wdata}) begin
                bad++;
                $display("FAIL rnd_mem cyc=%0d got=%b/%h/%h exp=%b/%h/%h", c, mem_we, mem_addr,
                         mem_wdata, e_we, e_addr, e_wdata);
            end
            total++;
            if ({cpu_rvalid, dbg_rvalid} !== {r_valid && !r_owner, r_valid && r_owner}) begin
                bad++;
                $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, {cpu_rvalid, dbg_rvalid},
                         {r_valid && !r_owner, r_valid && r_owner});
            end
            total++;
            if ({cpu_rdata, dbg_rdata} !== {e_crd, e_drd}) begin
                bad++;
                $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", c, cpu_rdata, dbg_rdata,
                         e_crd, e_drd);
            end

            n_valid = 1'b0; n_owner = 1'b0; n_data = '0;
            if (w_cpu || w_dbg) begin
                if (e_we) begin
                    ref_mem[e_addr[5:2]] = e_wdata;
                end else begin
                    n_valid = 1'b1;
                    n_owner = w_dbg;
                    n_data  = ref_mem[e_addr[5:2]];
                end
            end
            r_valid = n_valid; r_owner = n_owner; r_data = n_data;

            if (cpu_req && dbg_req && (w_cpu || w_dbg)) favour = w_cpu;
`ifdef DMEM_ARB_LOCK_EN
            if (!locked) begin
                if (w_dbg && dbg_lock) begin
                    locked = 1'b1;
                    lock_grants = 1;
                end
            end else begin
                if (w_dbg) lock_grants++;
                if (lock_grants == LOCK_MAX) begin
                    locked = 1'b0;
                    favour = 1'b0;
                end else if (!dbg_lock) begin
                    locked = 1'b0;
                end
            end
`endif
            cpu_pend = cpu_req && !w_cpu;
            dbg_pend = dbg_req && !w_dbg;
            next_cycle();
        end
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sram_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        next_cycle();
        sram_init = 1'b0;
        test_reset();
        test_contention();
        test_write_read();
        test_lock_release();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-ported synchronous data memory (`dataMem`) inside `top`. It shares the port between the CPU load/store unit (requester 0) and a debug/loader master (requester 1), which fills or inspects memory without halting the core. It provides round-robin arbitration, a bounded bus lock for debug bursts, and read-data return routing.

## Interface
Parameters:
- `AW`, 32: address width (byte address).
- `DW`, 32: data width.
- `LOCK_MAX`, 16: maximum consecutive locked grants to requester 1 before a forced release.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU access performed this cycle.
- `cpu_rdata`  out  DW  CPU read data.
- `cpu_rvalid`  out  1  `cpu_rdata` valid; one cycle after a granted CPU read.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rdata`, `dbg_rvalid`: same as the CPU ports, for requester 1.
- `dbg_lock`  in  1  keep grant on requester 1 across consecutive requests.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid the cycle after the address.

## Operation
- State registers:
  - `rr`: 0 means the CPU wins ties, 1 means debug wins ties.
  - `owner_q`: which requester issued the last read.
  - `rd_pend_q`: a read is in flight.
  - `lock_q`: lock is active.
  - `lock_cnt`: `$clog2(LOCK_MAX+1)` bits.
- Arbitration is combinational within the cycle:
  - Only one requester: that requester is granted.
  - Both requesting: the `rr` favourite is granted.
  - Lock active: debug only. `cpu_gnt`=0 even if the CPU is requesting.
- On a granted access, `mem_*` carry the winner's `we`/`addr`/`wdata`. With no grant, `mem_we`=0 and `mem_addr`/`mem_wdata` hold the previous value.
- `rr` update: after a contended grant, `rr` points to the loser. An uncontended grant leaves `rr` unchanged.
- Read return:
  - A granted read sets `rd_pend_q`=1 and records `owner_q`.
  - Next cycle: `mem_rdata` goes to the owner's `*_rdata`, and that owner's `*_rvalid` pulses for one cycle.
  - The non-owner's `*_rdata` holds its last value.
  - Back-to-back reads are allowed: a new grant in the same cycle as a return is legal.
- Granted writes produce no `rvalid`.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED when `dbg_gnt` && `dbg_lock`. `lock_cnt` is set to 1.
  - In LOCKED, each `dbg_gnt` increments `lock_cnt`.
  - LOCKED→UNLOCKED when `dbg_lock`=0, or `lock_cnt`==`LOCK_MAX` (forced).
  - A forced release sets `rr`=0. If the CPU is requesting, the CPU is granted in the next contended cycle.
- Reset, synchronous, mid-operation allowed:
  - Resulting values: `rr`=0, UNLOCKED, `rd_pend_q`=0, `lock_cnt`=0.
  - An in-flight read is dropped: no `rvalid` after reset.
  - Output values during and after reset: all `*_gnt`=0, `*_rvalid`=0, `*_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when the requester wins.
- Read latency is 1 cycle from grant to `rvalid`.
- A losing requester waits at most 1 cycle when unlocked. When locked, it waits at most `LOCK_MAX` cycles plus 1.
- Sustained throughput is one access per cycle.
- Simultaneous events:
  - `dbg_lock` rising in a cycle where the CPU wins: no lock is taken that cycle.
  - Forced release and the `dbg_lock` drop in the same cycle: single release, `rr`=0.
- Requesters must keep `we`/`addr`/`wdata` stable while `req` is high and `gnt` is low.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - The lock FSM, `lock_cnt` and `LOCK_MAX` enforcement are built.
- `DMEM_ARB_LOCK_EN` undefined:
  - `dbg_lock` is ignored and the lock state is always UNLOCKED.
  - Arbitration is pure round-robin.
  - The `LOCK_MAX` parameter stays in the interface but is unused.

## Test plan
- **Reset values:** reset held for 2 cycles while both requesters assert `req` → all outputs 0 during reset. First cycle after reset: `cpu_gnt`=1, `dbg_gnt`=0.
- **Contention:** both requesters read continuously at addresses 0x10 (CPU) and 0x20 (debug) for 6 cycles → grants alternate CPU, dbg, CPU, dbg, CPU, dbg. Each `rvalid` arrives exactly one cycle after its grant with the matching memory word.
- **Write then read:** debug writes 0xDEADBEEF to 0x8, then the CPU reads 0x8 → `cpu_rdata`=0xDEADBEEF with `cpu_rvalid` one cycle after `cpu_gnt`. No `dbg_rvalid` ever pulses.
- **Forced lock release:** `LOCK_MAX`=4, `dbg_lock`=1, both requesting continuously → 4 consecutive `dbg_gnt`, then `cpu_gnt`=1. With `DMEM_ARB_LOCK_EN` undefined, grants alternate instead.
- **Reset mid-read:** CPU read granted, reset asserted in the following cycle → `cpu_rvalid` stays 0, and `rr`/lock state return to their reset values.
- **Back-to-back reads:** CPU-only reads at 0x0, 0x4, 0x8 in three consecutive cycles → three consecutive `cpu_rvalid` pulses with in-order data.
